// File: rtl/jk_register_bank.sv
// Register bank of WIDTH JK flip-flop cells. HOLD, JK, TOGGLE and COUNT modes are all
// expressed as J/K vectors driving the same cell equation.
module jk_register_bank #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] t,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped
);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_JK     = 2'b01;
    localparam logic [1:0] MODE_TOGGLE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    logic [WIDTH-1:0] up_tgl;
    logic [WIDTH-1:0] down_tgl;
    logic [WIDTH-1:0] count_tgl;
    logic [WIDTH-1:0] terminal;
    logic             at_terminal;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] q_next;
    logic             counting;
    logic             tc_next;
    logic             wrap_event;

    // Synchronous-counter toggle chains: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        up_tgl      = '0;
        down_tgl    = '0;
        up_tgl[0]   = 1'b1;
        down_tgl[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            up_tgl[i]   = up_tgl[i-1] & q[i-1];
            down_tgl[i] = down_tgl[i-1] & ~q[i-1];
        end
    end

    assign terminal    = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign at_terminal = (q == terminal);
    assign counting    = en && (mode == MODE_COUNT);

    // Saturation freezes the counter by zeroing its toggle vector at the terminal value.
    always_comb begin
        count_tgl = dir ? up_tgl : down_tgl;
        if (SATURATE && at_terminal) begin
            count_tgl = '0;
        end
    end

    always_comb begin
        cell_j = '0;
        cell_k = '0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    cell_j = '0;
                    cell_k = '0;
                end
                MODE_JK: begin
                    cell_j = j;
                    cell_k = k;
                end
                MODE_TOGGLE: begin
                    cell_j = t;
                    cell_k = t;
                end
                MODE_COUNT: begin
                    cell_j = count_tgl;
                    cell_k = count_tgl;
                end
                default: begin
                    cell_j = '0;
                    cell_k = '0;
                end
            endcase
        end
    end

    assign q_next     = (cell_j & ~q) | (~cell_k & q);
    assign tc_next    = counting && (q_next == terminal);
    assign wrap_event = counting && at_terminal && !SATURATE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q       <= '0;
            tc      <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            q  <= q_next;
            tc <= tc_next;
            if (wrap_event) begin
                wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jk_register_bank.sv
// Bench for jk_register_bank: a wrapping and a saturating instance share stimulus; a
// queue-based scoreboard checks both against an arithmetic reference model.
module tb_jk_register_bank;

    localparam int W  = 8;
    localparam int SW = W + 2;
    localparam int EW = 2 * SW;

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_JK     = 2'b01;
    localparam logic [1:0] M_TOGGLE = 2'b10;
    localparam logic [1:0] M_COUNT  = 2'b11;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] j = '0;
    logic [W-1:0] k = '0;
    logic [W-1:0] t = '0;
    logic         dir = 1'b0;

    logic [W-1:0] q_wrap, q_sat;
    logic         tc_wrap, tc_sat;
    logic         wrapped_wrap, wrapped_sat;

    int tests = 0;
    int fails = 0;

    // Reference state: index 0 = wrapping instance, index 1 = saturating instance.
    logic [W-1:0] m_q [2];
    logic         m_tc[2];
    logic         m_w [2];

    logic [EW-1:0] exp_q[$];

    jk_register_bank #(.WIDTH(W), .SATURATE(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .t(t), .dir(dir),
        .q(q_wrap), .tc(tc_wrap), .wrapped(wrapped_wrap)
    );

    jk_register_bank #(.WIDTH(W), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .t(t), .dir(dir),
        .q(q_sat), .tc(tc_sat), .wrapped(wrapped_sat)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_q[s]  = '0;
            m_tc[s] = 1'b0;
            m_w[s]  = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] nq;
        logic [W-1:0] term;
        logic [W-1:0] maxv;
        maxv = {W{1'b1}};
        term = dir ? maxv : '0;
        for (int s = 0; s < 2; s++) begin
            nq = m_q[s];
            if (en) begin
                case (mode)
                    M_JK: begin
                        for (int b = 0; b < W; b++) begin
                            case ({j[b], k[b]})
                                2'b10:   nq[b] = 1'b1;
                                2'b01:   nq[b] = 1'b0;
                                2'b11:   nq[b] = ~m_q[s][b];
                                default: nq[b] = m_q[s][b];
                            endcase
                        end
                    end
                    M_TOGGLE: nq = m_q[s] ^ t;
                    M_COUNT: begin
                        if (m_q[s] == term) begin
                            if (s == 0) begin
                                nq     = dir ? '0 : maxv;
                                m_w[s] = 1'b1;
                            end
                        end else begin
                            nq = dir ? m_q[s] + 1'b1 : m_q[s] - 1'b1;
                        end
                    end
                    default: nq = m_q[s];
                endcase
            end
            m_tc[s] = en && (mode == M_COUNT) && (nq == term);
            m_q[s]  = nq;
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] jv,
                         input logic [W-1:0] kv, input logic [W-1:0] tv, input logic d);
        @(negedge clk);
        en   = e;
        mode = m;
        j    = jv;
        k    = kv;
        t    = tv;
        dir  = d;
        model_step();
        exp_q.push_back({m_q[0], m_tc[0], m_w[0], m_q[1], m_tc[1], m_w[1]});
    endtask

    task automatic set_q(input logic [W-1:0] v);
        drive(1'b1, M_JK, v, ~v, '0, 1'b0);
    endtask

    task automatic count_n(input int n, input logic d);
        for (int i = 0; i < n; i++) drive(1'b1, M_COUNT, '0, '0, '0, d);
    endtask

    task automatic check_now(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got q=%h tc=%b wrapped=%b, expected q=%h tc=%b wrapped=%b",
                     name, act[SW-1:2], act[1], act[0], exp[SW-1:2], exp[1], exp[0]);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_now("sb_wrap", {q_wrap, tc_wrap, wrapped_wrap}, e[EW-1:SW]);
            check_now("sb_sat", {q_sat, tc_sat, wrapped_sat}, e[SW-1:0]);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] v;
        int r;
        model_reset();

        // Reset held low while enabled for counting: everything stays at zero.
        en   = 1'b1;
        mode = M_COUNT;
        dir  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_now("reset_hold_wrap", {q_wrap, tc_wrap, wrapped_wrap}, '0);
        check_now("reset_hold_sat", {q_sat, tc_sat, wrapped_sat}, '0);
        @(negedge clk);
        en    = 1'b0;
        mode  = M_HOLD;
        reset = 1'b1;

        // Asynchronous reset between edges.
        set_q(8'h5A);
        @(posedge clk);
        #2;
        check_now("pre_async_reset", {q_wrap, tc_wrap, wrapped_wrap}, {8'h5A, 2'b00});
        reset = 1'b0;
        #1;
        check_now("async_reset_wrap", {q_wrap, tc_wrap, wrapped_wrap}, '0);
        check_now("async_reset_sat", {q_sat, tc_sat, wrapped_sat}, '0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // JK mode.
        set_q(8'h0F);
        drive(1'b1, M_JK, 8'hF0, 8'h3C, '0, 1'b0);
        drive(1'b1, M_JK, 8'hFF, 8'hFF, '0, 1'b0);
        @(posedge clk);
        #2;
        check_now("jk_toggle_all", {q_wrap, tc_wrap, wrapped_wrap}, {8'h0C, 2'b00});

        // TOGGLE mode.
        set_q(8'h00);
        drive(1'b1, M_TOGGLE, '0, '0, 8'hA5, 1'b0);
        drive(1'b1, M_TOGGLE, '0, '0, 8'hA5, 1'b0);
        drive(1'b1, M_TOGGLE, '0, '0, 8'h00, 1'b0);

        // Count up through the wrap point.
        set_q(8'hFD);
        count_n(3, 1'b1);
        @(posedge clk);
        #2;
        check_now("up_wrap", {q_wrap, tc_wrap, wrapped_wrap}, {8'h00, 2'b01});
        check_now("up_sat", {q_sat, tc_sat, wrapped_sat}, {8'hFF, 2'b10});

        // Count down into zero.
        set_q(8'h02);
        count_n(4, 1'b0);
        @(posedge clk);
        #2;
        check_now("down_sat", {q_sat, tc_sat, wrapped_sat}, {8'h00, 2'b10});

        // Enable / HOLD interaction.
        set_q(8'h10);
        count_n(2, 1'b1);
        repeat (3) drive(1'b0, M_COUNT, '0, '0, '0, 1'b1);
        repeat (2) drive(1'b1, M_HOLD, $urandom, $urandom, $urandom, 1'b1);
        count_n(2, 1'b1);
        @(posedge clk);
        #2;
        check_now("en_resume", {q_sat, tc_sat, wrapped_sat}, {8'h14, 2'b00});

        // Randomised traffic, biased towards COUNT and values near the terminals.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                case ($urandom_range(0, 4))
                    0: v = 8'h00;
                    1: v = 8'h01;
                    2: v = 8'hFE;
                    3: v = 8'hFF;
                    default: v = W'($urandom);
                endcase
                set_q(v);
            end else begin
                drive(($urandom_range(0, 9) != 0),
                      ($urandom_range(0, 1) != 0) ? M_COUNT : 2'($urandom_range(0, 2)),
                      W'($urandom), W'($urandom), W'($urandom),
                      ($urandom_range(0, 7) != 0) ? dir : ~dir);
            end
        end

        @(posedge clk);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish by 200000, expected completion");
        $fatal(1, "timeout");
    end

endmodule
